// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } bcd_state_e;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // ceil(width * log10(2)), using log10(2) ~= 0.30103 in fixed point
    function automatic int bcd_digits_for(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= BCD_ADJ_THRESH) begin
            digit_out = digit_in + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock,
// with ready/valid on both sides, optional signed input and overflow flag.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out,
    output logic                  ovf
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int ACC_W = 4 * DIGITS;

    bcd_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   mag_q, mag_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic               neg_q, neg_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic               sign_q, sign_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_shift;
    logic               carry_out;
    logic [BIN_W-1:0]   mag_shift;
    logic               neg_in;
    logic [BIN_W-1:0]   mag_in;
    logic               accept;
    logic               last_iter;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (acc_q[4*gi +: 4]),
            .digit_out (acc_adj[4*gi +: 4])
        );
    end

    assign acc_shift = {acc_adj[ACC_W-2:0], mag_q[BIN_W-1]};
    assign carry_out = acc_adj[ACC_W-1];
    assign mag_shift = {mag_q[BIN_W-2:0], 1'b0};
    assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

    // Negating -2^(BIN_W-1) wraps to itself, which is the correct unsigned magnitude
    assign neg_in = (SIGNED != 0) && bin_in[BIN_W-1];
    assign mag_in = neg_in ? (~bin_in + BIN_W'(1)) : bin_in;

    assign in_ready = !clr && ((state_q == IDLE) || (state_q == DONE && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mag_d       = mag_q;
        acc_d       = acc_q;
        ovf_acc_d   = ovf_acc_q;
        neg_d       = neg_q;
        bcd_d       = bcd_q;
        sign_d      = sign_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        if (clr) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                CONV: begin
                    acc_d     = acc_shift;
                    mag_d     = mag_shift;
                    ovf_acc_d = ovf_acc_q | carry_out;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        bcd_d       = acc_shift;
                        sign_d      = neg_q;
                        ovf_d       = ovf_acc_q | carry_out;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Accept is only possible from IDLE or a completing DONE, so it overrides both
            if (accept) begin
                state_d   = CONV;
                mag_d     = mag_in;
                neg_d     = neg_in;
                acc_d     = '0;
                ovf_acc_d = 1'b0;
                cnt_d     = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mag_q       <= '0;
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            neg_q       <= 1'b0;
            bcd_q       <= '0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mag_q       <= mag_d;
            acc_q       <= acc_d;
            ovf_acc_q   <= ovf_acc_d;
            neg_q       <= neg_d;
            bcd_q       <= bcd_d;
            sign_q      <= sign_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign sign_out  = sign_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Lockstep bench for three converter configurations (default, 3 digits, signed)
// sharing one input stream, checked against an arithmetic decimal model.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] bin_in = '0;
    logic        out_ready = 1'b1;

    logic        in_ready_a, out_valid_a, sign_a, ovf_a;
    logic [15:0] bcd_a;
    logic        in_ready_b, out_valid_b, sign_b, ovf_b;
    logic [11:0] bcd_b;
    logic        in_ready_c, out_valid_c, sign_c, ovf_c;
    logic [15:0] bcd_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_a),
        .bin_in(bin_in), .out_valid(out_valid_a), .out_ready(out_ready),
        .bcd_out(bcd_a), .sign_out(sign_a), .ovf(ovf_a)
    );

    bin2bcd_seq #(.BIN_W(12), .DIGITS(3), .SIGNED(0)) u_d3 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_b),
        .bin_in(bin_in), .out_valid(out_valid_b), .out_ready(out_ready),
        .bcd_out(bcd_b), .sign_out(sign_b), .ovf(ovf_b)
    );

    bin2bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_c),
        .bin_in(bin_in), .out_valid(out_valid_c), .out_ready(out_ready),
        .bcd_out(bcd_c), .sign_out(sign_c), .ovf(ovf_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Decimal reference: magnitude by arithmetic, digits by repeated division
    function automatic void model(input logic [11:0] v, input int digits, input bit sgn,
                                  output logic [15:0] bcd, output bit neg, output bit ov);
        int mag;
        int p;
        neg = sgn && v[11];
        mag = neg ? 4096 - int'(v) : int'(v);
        p = 1;
        bcd = '0;
        for (int k = 0; k < digits; k++) begin
            bcd[4*k +: 4] = 4'((mag / p) % 10);
            p = p * 10;
        end
        ov = (mag >= p);
    endfunction

    task automatic present(input logic [11:0] v, input bit b2b);
        int n;
        bin_in   = v;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (b2b) check_eq("b2b_ready", 32'(n), 32'd0);
        else     check_eq("accept_ready", 32'(in_ready_a), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        bin_in   = 12'($urandom);
    endtask

    task automatic run_txn(input logic [11:0] v, input bit b2b, input int stall, input bit next_b2b);
        int lat;
        logic [15:0] eb;
        bit en, eo;
        logic [15:0] held;
        present(v, b2b);
        lat = 0;
        while (!out_valid_a && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 32'(lat), 32'd12);
        check_eq("valid_d3", 32'(out_valid_b), 32'd1);
        check_eq("valid_sgn", 32'(out_valid_c), 32'd1);

        model(v, 4, 1'b0, eb, en, eo);
        check_eq("ovf_a", 32'(ovf_a), 32'(eo));
        if (!eo) check_eq("bcd_a", 32'(bcd_a), 32'(eb));
        check_eq("sign_a", 32'(sign_a), 32'd0);

        model(v, 3, 1'b0, eb, en, eo);
        check_eq("ovf_d3", 32'(ovf_b), 32'(eo));
        if (!eo) check_eq("bcd_d3", 32'(bcd_b), 32'(eb[11:0]));
        check_eq("sign_d3", 32'(sign_b), 32'd0);

        model(v, 4, 1'b1, eb, en, eo);
        check_eq("ovf_sgn", 32'(ovf_c), 32'(eo));
        if (!eo) check_eq("bcd_sgn", 32'(bcd_c), 32'(eb));
        check_eq("sign_sgn", 32'(sign_c), 32'(en));

        $display("txn in=%03h lat=%0d bcd4=%04h ovf4=%0d bcd3=%03h ovf3=%0d sbcd=%04h sign=%0d stall=%0d",
                 v, lat, bcd_a, ovf_a, bcd_b, ovf_b, bcd_c, sign_c, stall);

        held = bcd_a;
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            bin_in    = 12'($urandom);
            #1;
            check_eq("stall_in_ready", 32'(in_ready_a), 32'd0);
            @(negedge clk);
            check_eq("stall_valid", 32'(out_valid_a), 32'd1);
            check_eq("stall_bcd", 32'(bcd_a), 32'(held));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (!next_b2b) begin
            @(negedge clk);
            check_eq("valid_fall", 32'(out_valid_a), 32'd0);
        end
    endtask

    localparam int N_DIR = 9;
    localparam int N_RND = 16;

    initial begin
        logic [11:0] dir_v [N_DIR];
        logic [11:0] vals [N_DIR + N_RND];
        bit          b2b  [N_DIR + N_RND + 1];
        int          stl  [N_DIR + N_RND];
        logic [15:0] prev;
        bit          seen;

        dir_v = '{12'd190, 12'd4095, 12'd0, 12'd999, 12'd1000, 12'hF38, 12'h800, 12'd5, 12'd2047};
        for (int i = 0; i < N_DIR + N_RND + 1; i++) b2b[i] = 1'b0;
        for (int i = 0; i < N_DIR + N_RND; i++) begin
            vals[i] = (i < N_DIR) ? dir_v[i] : 12'($urandom);
            stl[i]  = 0;
            if (i >= N_DIR) begin
                b2b[i] = 1'($urandom_range(0, 1));
                stl[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            end
        end
        b2b[2] = 1'b1;
        stl[3] = 20;

        repeat (3) @(negedge clk);
        check_eq("rst_bcd", 32'(bcd_a), 32'd0);
        check_eq("rst_valid", 32'(out_valid_a), 32'd0);
        check_eq("rst_ovf", 32'(ovf_b), 32'd0);
        check_eq("rst_sign", 32'(sign_c), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("idle_in_ready", 32'(in_ready_a), 32'd1);

        for (int i = 0; i < N_DIR + N_RND; i++) begin
            run_txn(vals[i], b2b[i], stl[i], b2b[i+1]);
        end

        // Abort mid-conversion: previous result must survive, no result for 777
        prev = bcd_a;
        present(12'd777, 1'b0);
        repeat (4) @(negedge clk);
        clr = 1'b1;
        #1;
        check_eq("clr_in_ready", 32'(in_ready_a), 32'd0);
        @(negedge clk);
        clr  = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid_a) seen = 1'b1;
        end
        check_eq("clr_no_valid", 32'(seen), 32'd0);
        check_eq("clr_bcd_hold", 32'(bcd_a), 32'(prev));
        run_txn(12'd42, 1'b0, 0, 1'b0);

        // Asynchronous reset mid-conversion clears everything immediately
        present(12'($urandom), 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("arst_bcd", 32'(bcd_a), 32'd0);
        check_eq("arst_valid", 32'(out_valid_a), 32'd0);
        check_eq("arst_sbcd", 32'(bcd_c), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_txn(12'd42, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
